// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, PC register index,
// forward-select encodings and the per-stage destination tag.
package pipe_pkg;

    localparam int unsigned REG_W = 4;
    localparam logic [REG_W-1:0] PC_REG = 4'b1111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             load;
    } tag_t;

endpackage

// File: rtl/operand_hazard_unit_if.sv
// ID-stage operand/destination bundle in, forwarding selects and stall status out.
interface operand_hazard_unit_if
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             ID_Valid;
    logic [REG_W-1:0] SA;
    logic [REG_W-1:0] SB;
    logic [REG_W-1:0] SD;
    logic             UseA;
    logic             UseB;
    logic             UseD;
    logic [REG_W-1:0] ID_C;
    logic             ID_RFLd;
    logic             ID_Load;
    logic             Flush;
    logic [1:0]       FwdA;
    logic [1:0]       FwdB;
    logic [1:0]       FwdD;
    logic             Stall;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_Valid, SA, SB, SD, UseA, UseB, UseD, ID_C, ID_RFLd, ID_Load, Flush,
        input  FwdA, FwdB, FwdD, Stall, StallCount
    );

    modport slave (
        input  ID_Valid, SA, SB, SD, UseA, UseB, UseD, ID_C, ID_RFLd, ID_Load, Flush,
        output FwdA, FwdB, FwdD, Stall, StallCount
    );
endinterface

// File: rtl/fwd_select.sv
// Per-operand forward select: youngest matching stage wins; an EX-stage load
// match is reported as a hazard and leaves the select on the register file.
module fwd_select
    import pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  tag_t             ex_t,
    input  tag_t             mem_t,
    input  tag_t             wb_t,
    output logic [1:0]       sel,
    output logic             hazard
);
    logic rd_ok;
    logic ex_m;
    logic mem_m;
    logic wb_m;
    logic unused_load;

    // R15 is always sourced from the PC path, so it never matches.
    assign rd_ok = id_valid && use_src && (src != PC_REG);
    assign ex_m  = rd_ok && ex_t.valid  && (ex_t.dest  == src);
    assign mem_m = rd_ok && mem_t.valid && (mem_t.dest == src);
    assign wb_m  = rd_ok && wb_t.valid  && (wb_t.dest  == src);

    // MEM loads have data by end of MEM, so only the EX load bit matters.
    assign unused_load = mem_t.load ^ wb_t.load;

    always_comb begin
        sel    = FWD_RF;
        hazard = 1'b0;
        if (ex_m) begin
            if (ex_t.load) hazard = 1'b1;
            else           sel    = FWD_EX;
        end else if (mem_m) begin
            sel = FWD_MEM;
        end else if (wb_m) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/operand_hazard_unit.sv
// Decode-stage forwarding and load-use stall control with EX/MEM/WB destination
// tracking and a saturating stall-cycle counter.
module operand_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)(
    input  logic                 CLK,
    input  logic                 RST,
    operand_hazard_unit_if.slave bus
);
    tag_t             ex_t;
    tag_t             mem_t;
    tag_t             wb_t;
    logic             hz_a;
    logic             hz_b;
    logic             hz_d;
    logic             stall_c;
    logic [CNT_W-1:0] stall_cnt;

    fwd_select u_fwd_a (
        .id_valid (bus.ID_Valid), .src (bus.SA), .use_src (bus.UseA),
        .ex_t (ex_t), .mem_t (mem_t), .wb_t (wb_t),
        .sel (bus.FwdA), .hazard (hz_a)
    );

    fwd_select u_fwd_b (
        .id_valid (bus.ID_Valid), .src (bus.SB), .use_src (bus.UseB),
        .ex_t (ex_t), .mem_t (mem_t), .wb_t (wb_t),
        .sel (bus.FwdB), .hazard (hz_b)
    );

    fwd_select u_fwd_d (
        .id_valid (bus.ID_Valid), .src (bus.SD), .use_src (bus.UseD),
        .ex_t (ex_t), .mem_t (mem_t), .wb_t (wb_t),
        .sel (bus.FwdD), .hazard (hz_d)
    );

    // A squashed instruction cannot stall the pipe.
    assign stall_c        = (hz_a || hz_b || hz_d) && !bus.Flush;
    assign bus.Stall      = stall_c;
    assign bus.StallCount = stall_cnt;

    // Tags always advance; EX takes a bubble on flush or stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_t      <= '0;
            mem_t     <= '0;
            wb_t      <= '0;
            stall_cnt <= '0;
        end else begin
            mem_t <= ex_t;
            wb_t  <= mem_t;
            if (bus.Flush || stall_c) begin
                ex_t.valid <= 1'b0;
            end else begin
                ex_t <= '{valid: bus.ID_Valid && bus.ID_RFLd,
                          dest:  bus.ID_C,
                          load:  bus.ID_Load};
            end
            if (stall_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
endmodule
